reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
Parametrised register-file memory with one write port and two independent read ports. Supports per-byte write enables, registered reads with valid flags, and write-first bypass. A built-in clear engine sweeps every location to INIT_VAL after reset or on request. Used as the general-purpose register store beside the datapath, replacing the single-port reg_mem in new designs.

Parameters:
DATA_WIDTH, 8, word width in bits; must be a multiple of 8.
ADDR_BITS, 5, address width; DEPTH = 2**ADDR_BITS words.
INIT_VAL, 0, value written to every word by the clear engine.
BE_WIDTH, DATA_WIDTH/8, derived byte-enable width; not to be overridden.

Ports:
clk  in  1  clock, rising-edge active
rst  in  1  asynchronous reset, active-high
clr  in  1  request a full clear sweep
wen  in  1  write enable
waddr  in  ADDR_BITS  write address
wdata  in  DATA_WIDTH  write data
wbe  in  BE_WIDTH  byte enables; bit b covers wdata[8b+7:8b]
ren0  in  1  read request, port 0
raddr0  in  ADDR_BITS  read address, port 0
rdata0  out  DATA_WIDTH  registered read data, port 0
rvalid0  out  1  rdata0 updated this cycle
ren1, raddr1, rdata1, rvalid1: same as port 0, for port 1
busy  out  1  clear sweep in progress; all accesses ignored

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=ST_CLEAR, ptr=0, busy=1, rdata0=rdata1=0, rvalid0=rvalid1=0. The memory array itself is not reset; the sweep initialises it.
- FSM states: ST_IDLE and ST_CLEAR.
- ST_CLEAR:
  - Each rising edge writes INIT_VAL to mem[ptr], then ptr increments.
  - On the edge that writes DEPTH-1, the FSM moves to ST_IDLE and busy clears.
  - After rst deasserts, busy stays high for exactly DEPTH rising edges.
  - wen, ren0, ren1 and clr are ignored; rvalid0/1 are held at 0; rdata0/1 hold their values.
- ST_IDLE, clr=1: the next edge enters ST_CLEAR with ptr=0 and busy=1. A write in the same cycle is dropped (clr wins). Reads in the same cycle still complete.
- Write: with wen=1 in ST_IDLE, each byte b with wbe[b]=1 is updated at the edge; the other bytes are unchanged. wbe=0 with wen=1 is a no-op.
- Read latency is 1 cycle:
  - With ren_k=1 at an edge: rdata_k <= mem[raddr_k] and rvalid_k <= 1.
  - With ren_k=0: rvalid_k <= 0 and rdata_k holds.
- Write-first bypass: if wen=1 and waddr==raddr_k in the same cycle, enabled bytes come from wdata and the rest from mem. This applies to both ports independently.
- Both read ports may read the same address in the same cycle; no conflict.
- All DEPTH addresses are valid; there is no out-of-range case.
- rst asserted mid-sweep: the sweep restarts from ptr=0 and takes a full DEPTH cycles after release.

Decomposition:
- Package reg_file_pkg:
  - typedef enum {ST_IDLE, ST_CLEAR} rf_state_t.
  - Function byte_merge(old, new, be) returning the merged word, used by both the write path and the bypass.
- Sub-module reg_file_rd_port, instantiated twice:
  - Registered read with bypass.
  - Inputs: mem word, write-side signals, ren, raddr, busy.
  - Outputs: rdata, rvalid.

Test Plan:
1. Pulse rst, then release -> busy=1 for exactly 32 edges, then 0. Reading all 32 addresses on port 0 returns 0x00 with rvalid0=1 one cycle after each ren0.
2. Write 10..41 to addresses 0..31 (wbe=1). Then read port0 addr i and port1 addr 31-i -> rdata0=10+i and rdata1=41-i, 1-cycle latency, both rvalid high.
3. Same cycle: wen, waddr=7, wdata=0xA5, ren0 with raddr0=7 -> rdata0=0xA5 next cycle. A later read of addr 7 also returns 0xA5.
4. DATA_WIDTH=16 instance: write 0x1234 to addr 2, then 0xABCD with wbe=2'b10 -> read of addr 2 returns 0xAB34.
5. With data loaded: clr=1 with wen to addr 3, data 0x55 -> write dropped and busy high 32 cycles. ren0 during busy -> rvalid0=0. After busy falls, addr 3 reads 0x00.
6. Assert rst when ptr=10 mid-sweep -> busy stays 1 and ptr returns to 0. After release, busy lasts a full 32 edges and all words read INIT_VAL.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the two-read/one-write register file.
// Holds the controller state encoding and the byte-merge rule that the
// write path and the read bypass must apply identically.
package reg_file_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_t;

    // byte_merge works on a fixed maximum width so every instance can share
    // it; callers widen their operands and truncate the result back.
    localparam int RF_MAX_BE = 16;
    localparam int RF_MAX_DW = 8 * RF_MAX_BE;

    function automatic logic [RF_MAX_DW-1:0] byte_merge(
        input logic [RF_MAX_DW-1:0] old_w,
        input logic [RF_MAX_DW-1:0] new_w,
        input logic [RF_MAX_BE-1:0] be
    );
        logic [RF_MAX_DW-1:0] res;
        res = old_w;
        for (int b = 0; b < RF_MAX_BE; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port with write-first bypass.
// Latency 1 cycle: rdata/rvalid update on the edge that samples ren.
// No backpressure; requests are dropped while the clear sweep runs.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mem_word_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_BITS-1:0]  waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_WIDTH-1:0]   wbe_i,
    input  logic                  ren_i,
    input  logic [ADDR_BITS-1:0]  raddr_i,
    input  logic                  busy_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o
);

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    // Accept a read when idle; a same-cycle write to the same address wins.
    always_comb begin
        rvalid_d = ren_i & ~busy_i;
        rdata_d  = rdata_q;
        if (rvalid_d) begin
            if (wr_en_i && (waddr_i == raddr_i)) begin
                rdata_d = DATA_WIDTH'(byte_merge(RF_MAX_DW'(mem_word_i),
                                                 RF_MAX_DW'(wdata_i),
                                                 RF_MAX_BE'(wbe_i)));
            end else begin
                rdata_d = mem_word_i;
            end
        end
    end

    // Output registers; data holds whenever no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file, one byte-maskable write port and two registered read ports.
// Read latency 1 cycle with write-first bypass; clear sweep takes DEPTH edges.
// While busy (sweeping) all reads, writes and clear requests are ignored.
module reg_file_2r1w
    import reg_file_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_BITS  = 5,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    parameter int                    BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wen,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BE_WIDTH-1:0]   wbe,
    input  logic                  ren0,
    input  logic [ADDR_BITS-1:0]  raddr0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rvalid0,
    input  logic                  ren1,
    input  logic [ADDR_BITS-1:0]  raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rvalid1,
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    rf_state_t             state_q, state_d;
    logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] wr_word;

    assign busy = (state_q == ST_CLEAR);

    // A clear request in the same cycle drops the write.
    assign wr_fire = (state_q == ST_IDLE) & wen & ~clr;
    assign wr_word = DATA_WIDTH'(byte_merge(RF_MAX_DW'(mem_q[waddr]),
                                            RF_MAX_DW'(wdata),
                                            RF_MAX_BE'(wbe)));

    // Sweep controller: walk ptr across every word, then return to idle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Controller state; reset starts a fresh sweep from word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Storage array, deliberately unreset; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[ptr_q] <= INIT_VAL;
        end else if (wr_fire) begin
            mem_q[waddr] <= wr_word;
        end
    end

    reg_file_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .BE_WIDTH   (BE_WIDTH)
    ) u_rd0 (
        .clk        (clk),
        .rst        (rst),
        .mem_word_i (mem_q[raddr0]),
        .wr_en_i    (wr_fire),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .wbe_i      (wbe),
        .ren_i      (ren0),
        .raddr_i    (raddr0),
        .busy_i     (busy),
        .rdata_o    (rdata0),
        .rvalid_o   (rvalid0)
    );

    reg_file_rd_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (ADDR_BITS),
        .BE_WIDTH   (BE_WIDTH)
    ) u_rd1 (
        .clk        (clk),
        .rst        (rst),
        .mem_word_i (mem_q[raddr1]),
        .wr_en_i    (wr_fire),
        .waddr_i    (waddr),
        .wdata_i    (wdata),
        .wbe_i      (wbe),
        .ren_i      (ren1),
        .raddr_i    (raddr1),
        .busy_i     (busy),
        .rdata_o    (rdata1),
        .rvalid_o   (rvalid1)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: an 8-bit and a 16-bit instance share
// clock and reset; the stimulus pushes expected read data, a monitor pops it.
module tb_reg_file_2r1w;

    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       clr, wen, ren0, ren1;
    logic [4:0] waddr, raddr0, raddr1;
    logic [7:0] wdata, rdata0, rdata1;
    logic [0:0] wbe;
    logic       rvalid0, rvalid1, busy;

    // 16-bit instance (read port 1 unused)
    logic        h_wen = 1'b0, h_ren0 = 1'b0;
    logic [4:0]  h_waddr = '0, h_raddr0 = '0;
    logic [15:0] h_wdata = '0, h_rdata0, h_rdata1;
    logic [1:0]  h_wbe = '0;
    logic        h_rvalid0, h_rvalid1, h_busy;
    logic        h_clr = 1'b0, h_ren1 = 1'b0;
    logic [4:0]  h_raddr1 = '0;

    reg_file_2r1w #(.DATA_WIDTH(8), .ADDR_BITS(5), .INIT_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .clr(clr), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .ren0(ren0), .raddr0(raddr0),
        .rdata0(rdata0), .rvalid0(rvalid0), .ren1(ren1), .raddr1(raddr1),
        .rdata1(rdata1), .rvalid1(rvalid1), .busy(busy)
    );

    reg_file_2r1w #(.DATA_WIDTH(16), .ADDR_BITS(5), .INIT_VAL(16'h0000)) dut16 (
        .clk(clk), .rst(rst), .clr(h_clr), .wen(h_wen), .waddr(h_waddr),
        .wdata(h_wdata), .wbe(h_wbe), .ren0(h_ren0), .raddr0(h_raddr0),
        .rdata0(h_rdata0), .rvalid0(h_rvalid0), .ren1(h_ren1), .raddr1(h_raddr1),
        .rdata1(h_rdata1), .rvalid1(h_rvalid1), .busy(h_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: plain word arrays plus remaining-sweep counters.
    logic [7:0]  model   [DEPTH];
    logic [15:0] h_model [DEPTH];
    int          clr_left = 0;
    int          h_left   = 0;

    logic [7:0]  q0[$], q1[$];
    logic [15:0] qh[$];
    logic [7:0]  hold0 = '0, hold1 = '0;
    logic [15:0] hold_h = '0;

    function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n,
                                            input logic [1:0] be);
        logic [15:0] r;
        r = o;
        if (be[0]) r[7:0]  = n[7:0];
        if (be[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    // Monitor: every negedge, pop on valid, otherwise data must hold.
    always @(negedge clk) begin
        logic [7:0]  e8;
        logic [15:0] e16;
        vectors++;
        if (rvalid0) begin
            if (q0.size() == 0) begin
                miscompares++; $display("FAIL rd0_unexpected: rvalid0=1 rdata0=%h, required no read", rdata0);
            end else begin
                e8 = q0.pop_front(); hold0 = e8;
                if (rdata0 !== e8) begin miscompares++; $display("FAIL rd0_data: got %h, required %h", rdata0, e8); end
            end
        end else if (q0.size() != 0) begin
            e8 = q0.pop_front(); hold0 = e8;
            miscompares++; $display("FAIL rd0_missing: rvalid0=0, required 1 with %h", e8);
        end else if (rdata0 !== hold0) begin
            miscompares++; $display("FAIL rd0_hold: got %h, required %h", rdata0, hold0);
        end
        vectors++;
        if (rvalid1) begin
            if (q1.size() == 0) begin
                miscompares++; $display("FAIL rd1_unexpected: rvalid1=1 rdata1=%h, required no read", rdata1);
            end else begin
                e8 = q1.pop_front(); hold1 = e8;
                if (rdata1 !== e8) begin miscompares++; $display("FAIL rd1_data: got %h, required %h", rdata1, e8); end
            end
        end else if (q1.size() != 0) begin
            e8 = q1.pop_front(); hold1 = e8;
            miscompares++; $display("FAIL rd1_missing: rvalid1=0, required 1 with %h", e8);
        end else if (rdata1 !== hold1) begin
            miscompares++; $display("FAIL rd1_hold: got %h, required %h", rdata1, hold1);
        end
        vectors++;
        if (h_rvalid0) begin
            if (qh.size() == 0) begin
                miscompares++; $display("FAIL h_unexpected: rvalid=1 rdata=%h, required no read", h_rdata0);
            end else begin
                e16 = qh.pop_front(); hold_h = e16;
                if (h_rdata0 !== e16) begin miscompares++; $display("FAIL h_data: got %h, required %h", h_rdata0, e16); end
            end
        end else if (qh.size() != 0) begin
            e16 = qh.pop_front(); hold_h = e16;
            miscompares++; $display("FAIL h_missing: rvalid=0, required 1 with %h", e16);
        end else if (h_rdata0 !== hold_h) begin
            miscompares++; $display("FAIL h_hold: got %h, required %h", h_rdata0, hold_h);
        end
        vectors++;
        if (h_rvalid1 !== 1'b0 || h_rdata1 !== 16'h0) begin
            miscompares++; $display("FAIL h_port1_idle: got v=%b d=%h, required 0/0000", h_rvalid1, h_rdata1);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; wen = 0; waddr = '0; wdata = '0; wbe = '0;
        ren0 = 0; raddr0 = '0; ren1 = 0; raddr1 = '0;
        h_wen = 0; h_ren0 = 0; h_wbe = '0;
    endtask

    // One clock of stimulus on both instances, with model update and busy check.
    task automatic cyc(input logic w, input logic [4:0] wa, input logic [7:0] wd,
                       input logic wb, input logic r0, input logic [4:0] a0,
                       input logic r1, input logic [4:0] a1, input logic c);
        logic [7:0]  nv;
        logic [15:0] hv;
        wen = w; waddr = wa; wdata = wd; wbe = wb;
        ren0 = r0; raddr0 = a0; ren1 = r1; raddr1 = a1; clr = c;
        if (clr_left == 0) begin
            nv = wb ? wd : model[wa];
            if (r0) q0.push_back((w && !c && wa == a0) ? nv : model[a0]);
            if (r1) q1.push_back((w && !c && wa == a1) ? nv : model[a1]);
            if (c) begin
                for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
                clr_left = DEPTH;
            end else if (w) begin
                model[wa] = nv;
            end
        end else begin
            clr_left--;
        end
        if (h_left == 0) begin
            hv = merge16(h_model[h_waddr], h_wdata, h_wbe);
            if (h_ren0) qh.push_back((h_wen && h_waddr == h_raddr0) ? hv : h_model[h_raddr0]);
            if (h_wen) h_model[h_waddr] = hv;
        end else begin
            h_left--;
        end
        step();
        vectors++;
        if (busy !== (clr_left > 0)) begin
            miscompares++; $display("FAIL busy: got %b, required %b", busy, clr_left > 0);
        end
        vectors++;
        if (h_busy !== (h_left > 0)) begin
            miscompares++; $display("FAIL h_busy: got %b, required %b", h_busy, h_left > 0);
        end
        h_wen = 0; h_ren0 = 0; h_wbe = '0;
    endtask

    task automatic nop();
        cyc(0, 5'd0, 8'h00, 0, 0, 5'd0, 0, 5'd0, 0);
    endtask

    task automatic hcyc(input logic w, input logic [4:0] wa, input logic [15:0] wd,
                        input logic [1:0] wb, input logic r, input logic [4:0] ra);
        h_wen = w; h_waddr = wa; h_wdata = wd; h_wbe = wb; h_ren0 = r; h_raddr0 = ra;
        nop();
    endtask

    task automatic do_reset(input int edges);
        idle_inputs();
        rst = 1;
        q0.delete(); q1.delete(); qh.delete();
        hold0 = '0; hold1 = '0; hold_h = '0;
        #1;
        vectors++;
        if (busy !== 1'b1 || rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_state: got busy=%b v0=%b v1=%b d0=%h d1=%h, required 1 0 0 00 00",
                     busy, rvalid0, rvalid1, rdata0, rdata1);
        end
        for (int i = 0; i < edges; i++) begin
            step();
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_in_reset: got %b, required 1", busy); end
        end
        rst = 0;
        for (int i = 0; i < DEPTH; i++) begin model[i] = 8'h00; h_model[i] = 16'h0000; end
        clr_left = DEPTH;
        h_left   = DEPTH;
    endtask

    task automatic count_busy();
        int n;
        n = 0;
        do begin
            nop();
            n++;
        end while (busy === 1'b1 && n < 100);
        vectors++;
        if (n != DEPTH) begin miscompares++; $display("FAIL busy_length: got %0d edges, required %0d", n, DEPTH); end
    endtask

    initial begin
        idle_inputs();
        #1;
        // 1: reset, sweep length, all words read INIT_VAL
        do_reset(2);
        count_busy();
        for (int i = 0; i < DEPTH; i++) cyc(0, 5'd0, 8'h00, 0, 1, 5'(i), 0, 5'd0, 0);
        nop();

        // 2: fill 10..41, read both ports in opposite order
        for (int i = 0; i < DEPTH; i++) cyc(1, 5'(i), 8'(10 + i), 1, 0, 5'd0, 0, 5'd0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 5'd0, 8'h00, 0, 1, 5'(i), 1, 5'(31 - i), 0);
        nop();

        // 3: write-first bypass, then a plain read
        cyc(1, 5'd7, 8'hA5, 1, 1, 5'd7, 1, 5'd7, 0);
        cyc(0, 5'd0, 8'h00, 0, 1, 5'd7, 0, 5'd0, 0);
        cyc(1, 5'd8, 8'h3C, 0, 1, 5'd8, 0, 5'd0, 0);   // wbe=0: no-op, bypass shows old data
        nop();

        // 4: 16-bit byte-enable merge, including bypass with a partial mask
        hcyc(1, 5'd2, 16'h1234, 2'b11, 0, 5'd0);
        hcyc(1, 5'd2, 16'hABCD, 2'b10, 0, 5'd0);
        hcyc(0, 5'd0, 16'h0000, 2'b00, 1, 5'd2);
        hcyc(1, 5'd2, 16'h99EE, 2'b01, 1, 5'd2);
        hcyc(0, 5'd0, 16'h0000, 2'b00, 1, 5'd2);
        for (int i = 0; i < 40; i++)
            hcyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 16'($urandom),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
        nop();

        // 5: clear beats a same-cycle write; reads during the sweep are ignored
        cyc(1, 5'd3, 8'h55, 1, 1, 5'd3, 0, 5'd0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 5'd0, 8'h00, 0, 1, 5'($urandom_range(0, 31)), 1, 5'd3, 0);
        end
        cyc(0, 5'd0, 8'h00, 0, 1, 5'd3, 1, 5'd4, 0);
        nop();

        // random traffic with occasional clears
        for (int i = 0; i < 300; i++) begin
            h_wen = 1'($urandom_range(0, 1)); h_waddr = 5'($urandom_range(0, 7));
            h_wdata = 16'($urandom); h_wbe = 2'($urandom_range(0, 3));
            h_ren0 = 1'($urandom_range(0, 1)); h_raddr0 = 5'($urandom_range(0, 7));
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 59) == 0));
        end
        while (clr_left > 0) nop();
        for (int i = 0; i < DEPTH; i++) cyc(1, 5'(i), 8'($urandom), 1, 0, 5'd0, 0, 5'd0, 0);

        // 6: reset in the middle of a sweep restarts it from word 0
        cyc(0, 5'd0, 8'h00, 0, 0, 5'd0, 0, 5'd0, 1);
        for (int i = 0; i < 10; i++) nop();
        do_reset(3);
        count_busy();
        for (int i = 0; i < DEPTH; i++) cyc(0, 5'd0, 8'h00, 0, 1, 5'(i), 1, 5'(31 - i), 0);
        nop();
        nop();

        vectors++;
        if (q0.size() != 0 || q1.size() != 0 || qh.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d/%0d pending reads, required 0/0/0", q0.size(), q1.size(), qh.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
